vio_spi_master: RTL

Peripheral behind the CPU's video-I/O window in the lag-tester system: it accepts 16-bit words strobed by the CPU bus logic, queues them, and shifts each one out as a 16-bit SPI mode-0 transfer to the external video-I/O device while capturing the reply. It sits directly downstream of the system's `vio_en`/`vio_strobe`/`vio_din` outputs. It also produces the `vio_dout` status/data word and consumes the `vio_cfg` word.

---
 rtl/vio_pkg.sv | 26 ++
 rtl/vio_fifo.sv | 63 ++++++
 rtl/vio_spi_master.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vio_pkg.sv
// vio_pkg: shared FSM state type, status-word bit positions and defaults for the video-I/O SPI master
package vio_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    localparam int STAT_BUSY  = 15;
    localparam int STAT_FULL  = 14;
    localparam int STAT_EMPTY = 13;
    localparam int STAT_OVF   = 12;
    localparam int STAT_CNT   = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_GAP
    } state_e;

    // Queue count as shown in the 3-bit status field.
    function automatic logic [2:0] sat_count(input logic [4:0] c);
        return (c > 5'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/vio_fifo.sv
// vio_fifo: 16-bit synchronous TX queue with flush and occupancy count
//   clk, reset       : clock, asynchronous active-high reset
//   push_i, data_i   : write request and word (ignored when full)
//   pop_i            : read request (ignored when empty)
//   flush_i          : empties the queue; overrides push and pop
//   data_o           : word at the head of the queue
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored words
module vio_fifo
    import vio_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [15:0]   data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [15:0]   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vio_spi_master.sv
// vio_spi_master: queued 16-bit SPI mode-0 master behind the CPU video-I/O window
//   clk, reset      : clock, asynchronous active-high reset
//   vio_en          : enable; low aborts the transfer, flushes the queue, clears overflow
//   vio_strobe      : one-cycle push of vio_din
//   vio_din         : word to transmit
//   vio_dout        : status word, or last received word when vio_cfg[15]=1
//   vio_cfg         : [7:0] half-period divider D, [15] view select
//   spi_sclk/mosi/cs_n : SPI outputs (idle low / MSB first / active low)
//   spi_miso        : SPI input, already synchronous to clk
module vio_spi_master
    import vio_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vio_en,
    input  logic        vio_strobe,
    input  logic [15:0] vio_din,
    output logic [15:0] vio_dout,
    input  logic [15:0] vio_cfg,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q;
    state_e        state_d;
    logic [7:0]    hcnt_q;
    logic [3:0]    bit_q;
    logic [15:0]   tx_q;
    logic [15:0]   rx_sh_q;
    logic [15:0]   rx_data_q;
    logic [7:0]    rx_cnt_q;
    logic          ovf_q;
    logic          pop;
    logic          half_done;
    logic          moving;
    logic [15:0]   fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [15:0]   status;
    logic          cfg_unused;

    assign cfg_unused = ^vio_cfg[14:8];

    vio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (vio_strobe && vio_en),
        .data_i  (vio_din),
        .pop_i   (pop),
        .flush_i (!vio_en),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign half_done = hcnt_q == 8'd0;
    assign moving    = state_d != state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SETUP;
                    pop     = 1'b1;
                end
            end
            ST_SETUP:    if (half_done) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (half_done) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (half_done) state_d = (bit_q == 4'd15) ? ST_HOLD : ST_SHIFT_HI;
            ST_HOLD:     if (half_done) state_d = ST_GAP;
            ST_GAP: begin
                if (half_done) begin
                    state_d = fifo_empty ? ST_IDLE : ST_SETUP;
                    pop     = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!vio_en) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
        end
    end

    always_comb begin
        spi_cs_n = (state_q == ST_IDLE) || (state_q == ST_GAP);
        spi_sclk = state_q == ST_SHIFT_HI;
        spi_mosi = !spi_cs_n && tx_q[15];
    end

    // The divider is reloaded on every state change, so a new D applies from the next half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q    <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            rx_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            hcnt_q <= moving ? vio_cfg[7:0] : (half_done ? hcnt_q : hcnt_q - 8'd1);
            if (pop) begin
                tx_q  <= fifo_data;
                bit_q <= '0;
            end else if (state_q == ST_SHIFT_HI && state_d == ST_SHIFT_LO) begin
                tx_q <= {tx_q[14:0], 1'b0};
            end
            if (state_q == ST_SHIFT_LO && state_d == ST_SHIFT_HI) bit_q <= bit_q + 4'd1;
            // MISO is captured on the transition into SHIFT_HI, i.e. at the SCLK rising edge.
            if (moving && state_d == ST_SHIFT_HI) rx_sh_q <= {rx_sh_q[14:0], spi_miso};
            if (state_q == ST_HOLD && state_d == ST_GAP) begin
                rx_data_q <= rx_sh_q;
                rx_cnt_q  <= rx_cnt_q + 8'd1;
            end
            ovf_q <= vio_en && (ovf_q || (vio_strobe && fifo_full));
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_BUSY]      = state_q != ST_IDLE;
        status[STAT_FULL]      = fifo_full;
        status[STAT_EMPTY]     = fifo_empty;
        status[STAT_OVF]       = ovf_q;
        status[STAT_CNT +: 3]  = sat_count(5'(fifo_cnt));
        status[7:0]            = rx_cnt_q;
    end

    assign vio_dout = vio_cfg[15] ? rx_data_q : status;

endmodule
